// File: rtl/led_frequency_meter_pkg.sv
// Shared types and defaults for the LED frequency meter.
package led_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meter_state_t;

  localparam int unsigned DEF_GATE_CYCLES = 100_000_000;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Gate counter only ever holds GATE_CYCLES-1 down to 0.
  function automatic int unsigned gate_cnt_w(input int unsigned gate_cycles);
    return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/led_frequency_meter_sync_edge_detect.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// Pin-to-pulse latency is SYNC_STAGES+1 clocks; one pulse per rising edge.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pi_clk,
  input  logic pi_rstn,
  input  logic pi_async,
  output logic po_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   rise_q;
  logic                   rise_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pi_async};
  assign rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge pi_clk or negedge pi_rstn) begin
    if (!pi_rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= rise_d;
    end
  end

  assign po_rise = rise_q;

endmodule

// File: rtl/led_frequency_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and
// publishes count, valid strobe, range and overflow flags once per window.
module led_frequency_meter
  import led_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter logic [31:0] EXP_MIN     = 32'd1,
  parameter logic [31:0] EXP_MAX     = 32'hFFFF_FFFF,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             pi_clk,
  input  logic             pi_rstn,
  input  logic             pi_enable,
  input  logic             pi_signal,
  output logic [CNT_W-1:0] po_count,
  output logic             po_valid,
  output logic             po_busy,
  output logic             po_in_range,
  output logic             po_overflow
);

  localparam int unsigned       GATE_W    = gate_cnt_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  EXP_MIN_T = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  EXP_MAX_T = CNT_W'(EXP_MAX);

  meter_state_t      state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d, edge_inc;
  logic              sat_q, sat_d, sat_inc;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              in_range_q, in_range_d;
  logic              overflow_q, overflow_d;
  logic              rise;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .pi_clk   (pi_clk),
    .pi_rstn  (pi_rstn),
    .pi_async (pi_signal),
    .po_rise  (rise)
  );

  // Saturating edge count including this cycle's pulse.
  always_comb begin
    edge_inc = edge_q;
    sat_inc  = sat_q;
    if (rise) begin
      if (edge_q == CNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        edge_inc = edge_q + CNT_W'(1);
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_d     = edge_q;
    sat_d      = sat_q;
    count_d    = count_q;
    in_range_d = in_range_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pi_enable) state_d = ARM;
      end
      ARM: begin
        if (!pi_enable) begin
          state_d = IDLE;
        end else begin
          edge_d  = '0;
          sat_d   = 1'b0;
          gate_d  = GATE_LOAD;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!pi_enable) begin
          state_d = IDLE;
        end else begin
          edge_d = edge_inc;
          sat_d  = sat_inc;
          if (gate_q == '0) begin
            // Publish on entry to DONE so the strobe lines up with DONE.
            state_d    = DONE;
            valid_d    = 1'b1;
            count_d    = edge_inc;
            in_range_d = (edge_inc >= EXP_MIN_T) && (edge_inc <= EXP_MAX_T);
            overflow_d = sat_inc;
          end else begin
            gate_d = gate_q - GATE_W'(1);
          end
        end
      end
      DONE: begin
        state_d = pi_enable ? ARM : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ARM) || (state_d == MEASURE);
  end

  always_ff @(posedge pi_clk or negedge pi_rstn) begin
    if (!pi_rstn) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_range_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      in_range_q <= in_range_d;
      overflow_q <= overflow_d;
    end
  end

  assign po_count    = count_q;
  assign po_valid    = valid_q;
  assign po_busy     = busy_q;
  assign po_in_range = in_range_q;
  assign po_overflow = overflow_q;

endmodule

// File: tb/tb_led_frequency_meter.sv
// Bench for led_frequency_meter: directed windows with literal results plus
// randomized traffic compared every cycle against a window-level model.
module tb_led_frequency_meter;

  localparam int G    = 100;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;
  localparam int EMIN = 10;
  localparam int EMAX = 20;

  logic          clk;
  logic          rstn;
  logic          en;
  logic          sig;
  logic [CW-1:0] po_count;
  logic          po_valid;
  logic          po_busy;
  logic          po_in_range;
  logic          po_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  led_frequency_meter #(
    .GATE_CYCLES (G),
    .CNT_W       (CW),
    .EXP_MIN     (32'(EMIN)),
    .EXP_MAX     (32'(EMAX)),
    .SYNC_STAGES (2)
  ) dut (
    .pi_clk      (clk),
    .pi_rstn     (rstn),
    .pi_enable   (en),
    .pi_signal   (sig),
    .po_count    (po_count),
    .po_valid    (po_valid),
    .po_busy     (po_busy),
    .po_in_range (po_in_range),
    .po_overflow (po_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pin samples delayed through sync, window position as an integer
  // (-1 idle, 0 arm, 1..G measuring, G+1 done), true edge total clamped on publish.
  int            m_pos;
  int            m_cnt;
  logic          m_h1, m_h2, m_h3, m_h4, m_pulse;
  logic [CW-1:0] m_count;
  logic          m_valid, m_busy, m_inr, m_ovf;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pos = -1; m_cnt = 0; m_count = '0;
      m_valid = 1'b0; m_busy = 1'b0; m_inr = 1'b0; m_ovf = 1'b0;
      m_h1 = 1'b0; m_h2 = 1'b0; m_h3 = 1'b0; m_h4 = 1'b0;
    end else begin
      m_pulse = m_h3 & ~m_h4;
      m_valid = 1'b0;
      if (m_pos < 0) begin
        if (en) m_pos = 0;
      end else if (m_pos == G + 1) begin
        m_pos = en ? 0 : -1;
      end else if (!en) begin
        m_pos = -1;
      end else if (m_pos == 0) begin
        m_cnt = 0;
        m_pos = 1;
      end else begin
        m_cnt += int'(m_pulse);
        if (m_pos == G) begin
          m_count = (m_cnt > MAXC) ? CW'(MAXC) : CW'(m_cnt);
          m_ovf   = (m_cnt > MAXC);
          m_inr   = (int'(m_count) >= EMIN) && (int'(m_count) <= EMAX);
          m_valid = 1'b1;
          m_pos   = G + 1;
        end else begin
          m_pos++;
        end
      end
      m_busy = (m_pos >= 0) && (m_pos <= G);
      m_h4 = m_h3; m_h3 = m_h2; m_h2 = m_h1; m_h1 = sig;
    end
  end

  always @(negedge clk) begin
    chk("model_valid",    32'(po_valid),    32'(m_valid));
    chk("model_busy",     32'(po_busy),     32'(m_busy));
    chk("model_count",    32'(po_count),    32'(m_count));
    chk("model_in_range", 32'(po_in_range), 32'(m_inr));
    chk("model_overflow", 32'(po_overflow), 32'(m_ovf));
  end

  // Stimulus: one driver; sig pattern chosen by mode each falling edge.
  int mode = 0;
  int ph   = 0;
  int rate = 4;

  task automatic step();
    @(negedge clk);
    ph++;
    case (mode)
      0: sig = 1'b0;
      1: sig = 1'b1;
      2: sig = ((ph % 10) < 5);
      3: sig = ph[0];
      4: if ($urandom_range(0, rate - 1) == 0) sig = ~sig;
      default: ;
    endcase
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!po_valid && n < 400);
    if (!po_valid) chk({name, "_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic check_result(input string name, input int c, input int inr, input int ovf);
    chk({name, "_count"},    32'(po_count),    32'(c));
    chk({name, "_in_range"}, 32'(po_in_range), 32'(inr));
    chk({name, "_overflow"}, 32'(po_overflow), 32'(ovf));
  endtask

  // Pulse sampled high only at reference+a and reference+b; check window two ahead.
  task automatic pulse_window(input string name, input int a, input int b, input int exp_cnt);
    for (int j = 1; j <= 2 * (G + 2); j++) begin
      step();
      sig = ((j + 1) == a) || ((j + 1) == b);
    end
    chk({name, "_valid"}, 32'(po_valid), 32'd1);
    chk({name, "_count"}, 32'(po_count), 32'(exp_cnt));
  endtask

  initial begin
    int n;
    int seen;
    sig = 1'b0; en = 1'b0; rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) step();
    chk("reset_count", 32'(po_count), 32'd0);
    chk("reset_valid", 32'(po_valid), 32'd0);
    chk("reset_busy",  32'(po_busy),  32'd0);
    check_result("reset", 0, 0, 0);
    step();
    rstn = 1'b1;

    // Square wave, period 10: every 100-cycle window sees exactly 10 rises.
    mode = 2; en = 1'b1;
    wait_valid("sq_first", n);
    wait_valid("sq_second", n);
    check_result("sq", 10, 1, 0);
    wait_valid("sq_third", n);
    chk("sq_spacing", 32'(n), 32'(G + 2));
    check_result("sq3", 10, 1, 0);

    // Abort halfway through a window.
    repeat (50) step();
    en = 1'b0;
    step(); step();
    chk("abort_busy", 32'(po_busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (po_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_count_hold", 32'(po_count), 32'd10);

    // Static input, low then high.
    mode = 0; en = 1'b1;
    wait_valid("low1", n);
    wait_valid("low2", n);
    check_result("low", 0, 0, 0);
    mode = 1;
    wait_valid("high1", n);
    wait_valid("high2", n);
    check_result("high", 0, 0, 0);

    // Toggle every cycle: 50 rises saturate a 5-bit counter, then recover.
    mode = 3;
    wait_valid("fast1", n);
    wait_valid("fast2", n);
    check_result("fast", MAXC, 0, 1);
    mode = 0;
    wait_valid("clr1", n);
    wait_valid("clr2", n);
    check_result("clr", 0, 0, 0);

    // Pulses in first/last measuring cycles count; in arm/done they do not.
    mode = 5; sig = 1'b0;
    pulse_window("edge_in", G + 2, 2 * G + 1, 2);
    pulse_window("edge_dead", G + 1, 2 * G + 2, 0);

    // Randomized traffic with enable drops; the model checks every cycle.
    mode = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 1;
          1: rate = 2;
          2: rate = 5;
          default: rate = 16;
        endcase
      end
      step();
      if (en && $urandom_range(0, 399) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
    end

    // Asynchronous reset mid-window, then first result GATE+2 cycles after release.
    mode = 2; en = 1'b1;
    repeat (150) step();
    #2 rstn = 1'b0;
    #1;
    chk("areset_count", 32'(po_count), 32'd0);
    chk("areset_valid", 32'(po_valid), 32'd0);
    chk("areset_busy",  32'(po_busy),  32'd0);
    chk("areset_in_range", 32'(po_in_range), 32'd0);
    chk("areset_overflow", 32'(po_overflow), 32'd0);
    step(); step();
    rstn = 1'b1;
    wait_valid("post_reset", n);
    chk("post_reset_latency", 32'(n), 32'(G + 2));

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
